instr_queue: RTL



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_queue.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the {pc, instr} entry and HALT opcode decode.
package fetch_pkg;

   localparam int unsigned PCW_DEF    = 32;
   localparam int unsigned INSTRW_DEF = 16;

   // Opcode lives in the top five instruction bits.
   localparam int unsigned OPC_HI = INSTRW_DEF - 1;
   localparam int unsigned OPC_LO = INSTRW_DEF - 5;

   localparam logic [4:0] HALT_OPCODE = 5'b00000;

   typedef struct packed {
      logic [PCW_DEF-1:0]    pc;
      logic [INSTRW_DEF-1:0] instr;
   } fetch_entry_t;

   function automatic logic is_halt(input logic [INSTRW_DEF-1:0] instr);
      return instr[OPC_HI:OPC_LO] == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO with flush on redirect and HALT tracking.
// Occupancy count is the only full/empty source; pointers simply wrap.
module instr_queue
   import fetch_pkg::*;
#(
   // PCW/INSTRW must match the fetch_entry_t field widths in fetch_pkg.
   parameter int unsigned PCW    = PCW_DEF,
   parameter int unsigned INSTRW = INSTRW_DEF,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNTW   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [INSTRW-1:0] in_instr,
   input  logic [PCW-1:0]    in_pc,
   output logic              stall_out,
   input  logic              flush,
   output logic              out_valid,
   output logic [INSTRW-1:0] out_instr,
   output logic [PCW-1:0]    out_pc,
   input  logic              out_ready,
   output logic              halt_seen,
   output logic              halted,
   output logic [CNTW-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t          mem_q [DEPTH];
   fetch_entry_t          head;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic                  halt_seen_q, halt_seen_d;
   logic                  halted_q, halted_d;
   logic                  full;
   logic                  push;
   logic                  pop;

   // Status and handshake decode, all from registered state except push/pop.
   always_comb begin
      full      = (count_q == CNTW'(DEPTH));
      out_valid = (count_q != '0);
      stall_out = full | halt_seen_q;
      push      = in_valid & ~full & ~halt_seen_q & ~flush;
      pop       = out_valid & out_ready & ~flush;
      head      = mem_q[rd_ptr_q];
      // Gate the head so stale storage never shows while empty.
      out_instr = out_valid ? head.instr : '0;
      out_pc    = out_valid ? head.pc : '0;
      halt_seen = halt_seen_q;
      halted    = halted_q;
      count     = count_q;
   end

   // Next-state for pointers, occupancy and HALT flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      halt_seen_d = halt_seen_q;
      halted_d    = halted_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         halt_seen_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop) count_d = count_q + CNTW'(1);
         if (pop && !push) count_d = count_q - CNTW'(1);
         if (push && is_halt(in_instr)) halt_seen_d = 1'b1;
      end
      // pop already excludes flush; halted is sticky until reset.
      if (pop && is_halt(head.instr)) halted_d = 1'b1;
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         halt_seen_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         halt_seen_q <= halt_seen_d;
         halted_q    <= halted_d;
      end
   end

   // Entry storage; contents need no reset since out_* are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
      end
   end

endmodule
